// File: rtl/imem_loader_if.sv
// Byte-stream input and instruction-memory write port of the loader.
// Handshake: a byte transfers on a rising edge where in_valid=1 and in_ready=1; in_ready never depends on in_valid.
interface imem_loader_if;
  logic       in_valid;
  logic [7:0] in_data;
  logic       in_last;
  logic       in_ready;
  logic       mem_we;
  logic [8:0] mem_addr;
  logic [7:0] mem_wdata;

  modport master (
    output in_valid, in_data, in_last,
    input  in_ready, mem_we, mem_addr, mem_wdata
  );

  modport slave (
    input  in_valid, in_data, in_last,
    output in_ready, mem_we, mem_addr, mem_wdata
  );
endinterface

// File: rtl/imem_loader.sv
// Streams a big-endian program into byte-wide instruction memory and holds the
// pipeline in reset until a whole-word load has completed cleanly.
module imem_loader #(
  parameter logic [8:0] BASE_ADDR = 9'd0,
  parameter int         MAX_BYTES = 512
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  imem_loader_if.slave bus,
  output logic        pipe_hold,
  output logic        done,
  output logic        error,
  output logic [7:0]  word_count,
  output logic [7:0]  checksum,
  output logic [1:0]  dbg_state_o
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_LOAD = 2'd1,
    S_DONE = 2'd2,
    S_ERR  = 2'd3
  } state_e;

  localparam logic [9:0] MAX_CNT = 10'(MAX_BYTES);

  state_e     state_q, state_d;
  logic [9:0] cnt_q, cnt_d;
  logic       we_q, we_d;
  logic [8:0] addr_q, addr_d;
  logic [7:0] wdata_q, wdata_d;
  logic [7:0] wc_q, wc_d;
  logic [7:0] cs_q, cs_d;
  logic       hs;

  assign hs = bus.in_valid && (state_q == S_LOAD);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    we_d    = 1'b0;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    wc_d    = wc_q;
    cs_d    = cs_q;
    unique case (state_q)
      S_LOAD: begin
        if (hs) begin
          // A byte beyond capacity is consumed but never written.
          if (cnt_q == MAX_CNT) begin
            state_d = S_ERR;
          end else begin
            we_d    = 1'b1;
            addr_d  = BASE_ADDR + cnt_q[8:0];
            wdata_d = bus.in_data;
            cnt_d   = cnt_q + 10'd1;
            cs_d    = cs_q ^ bus.in_data;
            if (cnt_q[1:0] == 2'd3) wc_d = wc_q + 8'd1;
            if (bus.in_last) state_d = (cnt_q[1:0] == 2'd3) ? S_DONE : S_ERR;
          end
        end
      end
      default: begin
        if (start) begin
          state_d = S_LOAD;
          cnt_d   = 10'd0;
          wc_d    = 8'd0;
          cs_d    = 8'd0;
        end
      end
    endcase
  end

  // Reset wins over a handshake on the same edge, so its write never issues.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= S_IDLE;
      cnt_q   <= 10'd0;
      we_q    <= 1'b0;
      addr_q  <= 9'd0;
      wdata_q <= 8'd0;
      wc_q    <= 8'd0;
      cs_q    <= 8'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      wc_q    <= wc_d;
      cs_q    <= cs_d;
    end
  end

  assign bus.in_ready  = (state_q == S_LOAD);
  assign bus.mem_we    = we_q;
  assign bus.mem_addr  = addr_q;
  assign bus.mem_wdata = wdata_q;
  assign pipe_hold     = (state_q != S_DONE);
  assign done          = (state_q == S_DONE);
  assign error         = (state_q == S_ERR);
  assign word_count    = wc_q;
  assign checksum      = cs_q;
  assign dbg_state_o   = state_q;

endmodule

// File: doc/imem_loader.md
IMEM_LOADER -- requirements
Module: imem_loader

Interface
REQ-001 Parameter BASE_ADDR, default 9'd0, first instruction-memory byte address written after each start.
REQ-002 Parameter MAX_BYTES, default 512, byte capacity of instruction memory (multiple of 4, at most 512).
REQ-003 The block SHALL have one clock, and its reset SHALL be synchronous and active-low.
REQ-004 clk  input  1  rising-edge clock.
REQ-005 reset  input  1  synchronous active-low reset.
REQ-006 start  input  1  single-cycle pulse that arms a new load.
REQ-007 in_valid  input  1  source byte valid.
REQ-008 in_data  input  8  program byte, big-endian within each 32-bit instruction.
REQ-009 in_last  input  1  marks the final byte of the program, qualified by in_valid.
REQ-010 in_ready  output  1  loader accepts a byte this cycle.
REQ-011 mem_we  output  1  instruction-memory byte write strobe.
REQ-012 mem_addr  output  9  instruction-memory byte address.
REQ-013 mem_wdata  output  8  instruction-memory write byte.
REQ-014 pipe_hold  output  1  holds PC, nPC and IF/ID in reset while high.
REQ-015 done  output  1  load completed cleanly.
REQ-016 error  output  1  load aborted.
REQ-017 word_count  output  8  complete 32-bit instructions written.
REQ-018 checksum  output  8  XOR of all bytes accepted in the current load.

Function
REQ-019 States SHALL be IDLE, LOAD, DONE and ERR, and the block SHALL accept a byte (handshake) only on a cycle with in_valid=1 and in_ready=1.
REQ-020 in_ready SHALL be 1 only in LOAD and SHALL be combinationally independent of in_valid.
REQ-021 On start in IDLE, DONE or ERR, the block SHALL go to LOAD and clear the byte pointer to BASE_ADDR, word_count to 0, checksum to 0, done to 0 and error to 0.
REQ-022 start SHALL be ignored while in LOAD.
REQ-023 Each handshake SHALL produce a registered write one cycle later: mem_we=1, mem_addr=pointer at the handshake, mem_wdata=in_data.
REQ-024 On each handshake the pointer SHALL increment by 1 and checksum SHALL be XORed with in_data.
REQ-025 word_count SHALL increment by 1 in the cycle after a handshake whose byte is at offset 3 (mod 4) relative to BASE_ADDR.
REQ-026 A handshake with in_last=1 at offset 3 (mod 4) SHALL move the block to DONE, with done=1 in the same cycle as the final mem_we.
REQ-027 A handshake with in_last=1 at any other offset SHALL still write its byte, SHALL then move the block to ERR with error=1, and SHALL NOT increment word_count for the partial word.
REQ-028 A handshake that would make the byte count exceed MAX_BYTES SHALL NOT write, SHALL move the block to ERR, and mem_addr SHALL never wrap past BASE_ADDR+MAX_BYTES-1.
REQ-029 Accepting exactly MAX_BYTES bytes with in_last on the final byte SHALL be legal and SHALL move the block to DONE.
REQ-030 pipe_hold SHALL be 1 in IDLE, LOAD and ERR, and 0 only in DONE.
REQ-031 done and error SHALL be sticky until the next start or reset, and SHALL never both be 1.
REQ-032 mem_we SHALL be 0 in every cycle not following a handshake.
REQ-033 The block SHALL NOT issue a new byte write in ERR or DONE.

Reset
REQ-034 When reset=0 at a rising edge, the block SHALL enter IDLE with in_ready=0, mem_we=0, mem_addr=0, mem_wdata=0, pipe_hold=1, done=0, error=0, word_count=0 and checksum=0.
REQ-035 Reset asserted mid-LOAD SHALL abort the load immediately; any write registered from the handshake on that same edge SHALL be suppressed, and bytes already written SHALL remain in memory.
REQ-036 After reset the block SHALL require start to load again.

Verification
REQ-037 Start, then bytes 24 09 00 05 with last on 05 -> writes at addresses 0..3, word_count=1, checksum=0x28, done=1, pipe_hold=0.
REQ-038 Start, then 6 bytes with last on byte 6 -> 6 writes, word_count=1, error=1, done=0, pipe_hold=1.
REQ-039 Start, then 513 bytes with no last -> 512 writes at addresses 0..511, no write for byte 513, error=1, word_count=128.
REQ-040 Start, then in_valid toggled randomly over 8 bytes -> writes only on handshake cycles, addresses contiguous 0..7, done=1.
REQ-041 Reset pulled low after the 2nd of 4 bytes -> mem_we=0 from that edge onward, IDLE with all outputs at reset values; start pulse ignored during LOAD in a separate run -> pointer unaffected.
REQ-042 BASE_ADDR=9'd16 with 4 bytes and last -> writes at addresses 16..19, done=1.
